ub_intr_arb: RTL

- Interrupt priority arbiter for one IO bus adapter.
- Collects per-device interrupt requests from device interrupt controllers such as the DZ11 RX/TX controller and the LP/RH controllers. Each request carries a bus-request level, BR4..BR7.
- Presents a 4-bit level summary to the adapter.
- On an interrupt-acknowledge cycle it selects one winning device, sends that device its acknowledge strobe, latches the device's vector and returns it to the adapter. Within a level, devices are served round-robin.

---
 rtl/ub_intr_pkg.sv | 18 +
 rtl/ub_rr_pick.sv | 37 +++
 rtl/ub_intr_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/ub_intr_pkg.sv
// Shared types and constants for the IO bus interrupt arbiter.
package ub_intr_pkg;

  // Acknowledge-cycle sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StAck,
    StRelease
  } arbState_t;

  // Bus-request levels as carried on devLVL / iackLVL.
  localparam logic [1:0] BR4 = 2'd0;
  localparam logic [1:0] BR5 = 2'd1;
  localparam logic [1:0] BR6 = 2'd2;
  localparam logic [1:0] BR7 = 2'd3;

endpackage

// File: rtl/ub_rr_pick.sv
// Combinational round-robin first-one finder: first set bit of cand at or above ptr,
// wrapping modulo NDEV.
module ub_rr_pick #(
  parameter int unsigned NDEV = 4
) (
  input  logic [NDEV-1:0]         cand,
  input  logic [$clog2(NDEV)-1:0] ptr,
  output logic [$clog2(NDEV)-1:0] win,
  output logic                    valid
);

  localparam int unsigned PW = $clog2(NDEV);

  logic [2*NDEV-1:0] dbl;
  logic [PW:0]       idx;

  // Scan a doubled request vector over the window [ptr, ptr+NDEV), then fold the index back.
  always_comb begin
    dbl   = {cand, cand};
    idx   = '0;
    valid = 1'b0;
    win   = '0;
    // Downward scan so the lowest matching position wins.
    for (int j = int'(2 * NDEV) - 1; j >= 0; j--) begin
      if (dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + int'(NDEV))) begin
        idx   = (PW + 1)'(j);
        valid = 1'b1;
      end
    end
    for (int i = 0; i < int'(NDEV); i++) begin
      if ((idx == (PW + 1)'(i)) || (idx == (PW + 1)'(i + int'(NDEV)))) begin
        win = PW'(i);
      end
    end
  end

endmodule

// File: rtl/ub_intr_arb.sv
// Interrupt priority arbiter for one IO bus adapter: level summary plus a round-robin
// acknowledge sequencer that latches the winning device's vector.
module ub_intr_arb
  import ub_intr_pkg::*;
#(
  parameter int unsigned NDEV  = 4,
  parameter int unsigned VECTW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NDEV-1:0]       devREQ,
  input  logic [2*NDEV-1:0]     devLVL,
  input  logic [VECTW*NDEV-1:0] devVECT,
  output logic [3:0]            busINTR,
  input  logic                  iackREQ,
  input  logic [1:0]            iackLVL,
  output logic [NDEV-1:0]       devIACK,
  output logic [VECTW-1:0]      iackVECT,
  output logic                  iackACK,
  output logic                  iackNXD
);

  localparam int unsigned PW = $clog2(NDEV);

  arbState_t        state;
  logic [1:0]       lvlReg;
  logic [PW-1:0]    rrPtr;
  logic [NDEV-1:0]  cand;
  logic [PW-1:0]    win;
  logic             winValid;
  logic [VECTW-1:0] winVect;

  // Level summary: one bit per BR level with any pending request.
  always_comb begin
    busINTR = '0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (devREQ[i]) busINTR[devLVL[2*i +: 2]] = 1'b1;
    end
  end

  // Candidates are live requests at the level latched for this acknowledge.
  always_comb begin
    cand = '0;
    for (int i = 0; i < int'(NDEV); i++) begin
      cand[i] = devREQ[i] & (devLVL[2*i +: 2] == lvlReg);
    end
  end

  ub_rr_pick #(
    .NDEV(NDEV)
  ) u_rr_pick (
    .cand (cand),
    .ptr  (rrPtr),
    .win  (win),
    .valid(winValid)
  );

  // Vector mux for the current winner.
  always_comb begin
    winVect = '0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (win == PW'(i)) winVect = devVECT[i*VECTW +: VECTW];
    end
  end

  // Acknowledge sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      lvlReg   <= BR4;
      rrPtr    <= '0;
      devIACK  <= '0;
      iackVECT <= '0;
      iackACK  <= 1'b0;
      iackNXD  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (iackREQ) begin
            lvlReg <= iackLVL;
            state  <= StSelect;
          end
        end
        StSelect: begin
          if (winValid) begin
            devIACK  <= NDEV'(1) << win;
            iackVECT <= winVect;
            iackACK  <= 1'b1;
            // Explicit wrap keeps non-power-of-2 NDEV inside 0..NDEV-1.
            rrPtr    <= (win == PW'(NDEV - 1)) ? '0 : win + 1'b1;
          end else begin
            iackNXD  <= 1'b1;
            iackVECT <= '0;
          end
          state <= StAck;
        end
        StAck: begin
          // Outputs stay frozen until the adapter drops its request.
          if (!iackREQ) begin
            devIACK  <= '0;
            iackVECT <= '0;
            iackACK  <= 1'b0;
            iackNXD  <= 1'b0;
            state    <= StRelease;
          end
        end
        StRelease: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
